eth_pcs_rx_gearbox: RTL and testbench

Receive-side 32:66 gearbox of the 10GBASE-R PCS. It sits between the PMA receive interface and the descrambler/block-lock logic. It accepts one W_DATA-bit PMA word every cycle and re-frames the serial stream into 66-bit blocks, presented as a sync header plus two W_DATA-bit halves. It provides a one-bit slip so the block-lock FSM can walk the alignment until sync headers are found.

---
 rtl/eth_pcs_rx_gearbox.sv | 67 ++++++
 tb/tb_eth_pcs_rx_gearbox.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_rx_gearbox.sv
// eth_pcs_rx_gearbox: 32:66 receive gearbox re-framing PMA words into sync header plus two data halves, with one-bit slip
module eth_pcs_rx_gearbox #(
  parameter int W_DATA           = 32,
  parameter int W_SYNC           = 2,
  parameter int W_RX_GEARBOX_BUF = 2*W_DATA+1,
  parameter int W_TRANS_PER_BLK  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [W_DATA-1:0]          i_pma_data,
  input  logic                       i_slip,
  output logic                       o_valid,
  output logic [W_SYNC-1:0]          o_sync_data,
  output logic [W_DATA-1:0]          o_data,
  output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt
);
  localparam int B  = W_RX_GEARBOX_BUF;
  localparam int WF = $clog2(W_DATA+2);
  localparam int WA = WF+1;
  localparam logic [WA-1:0] A_DATA  = WA'(W_DATA);
  localparam logic [WA-1:0] A_FIRST = WA'(W_SYNC+W_DATA);
  logic [B-1:0]               buf_q, buf_d, merged, slipped;
  logic [WF-1:0]              fill_q, fill_d;
  logic [WA-1:0]              avail;
  logic                       phase_q, phase_d, valid_q, valid_d, emit0, emit1;
  logic [W_SYNC-1:0]          sync_q, sync_d;
  logic [W_DATA-1:0]          data_q, data_d;
  logic [W_TRANS_PER_BLK-1:0] trans_q, trans_d;
  // buffer is left-justified: oldest bit at the MSB, unused bits below the fill level are zero
  always_comb begin
    merged  = buf_q | ({i_pma_data, {(B-W_DATA){1'b0}}} >> fill_q);
    slipped = i_slip ? merged << 1 : merged;
    avail   = WA'(fill_q) + A_DATA - WA'(i_slip);
    emit0   = !phase_q && avail >= A_FIRST;
    emit1   = phase_q && avail >= A_DATA;
    buf_d   = emit0 ? slipped << (W_SYNC+W_DATA) : emit1 ? slipped << W_DATA : slipped;
    fill_d  = WF'(emit0 ? avail - A_FIRST : emit1 ? avail - A_DATA : avail);
    phase_d = (emit0 || emit1) ? !phase_q : phase_q;
    valid_d = emit0 || emit1;
    sync_d  = emit0 ? slipped[B-1 -: W_SYNC] : sync_q;
    data_d  = emit0 ? slipped[B-1-W_SYNC -: W_DATA] : emit1 ? slipped[B-1 -: W_DATA] : data_q;
    trans_d = emit0 ? '0 : emit1 ? W_TRANS_PER_BLK'(1) : trans_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      buf_q   <= '0;
      fill_q  <= '0;
      phase_q <= 1'b0;
      valid_q <= 1'b0;
      sync_q  <= '0;
      data_q  <= '0;
      trans_q <= '0;
    end else begin
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      trans_q <= trans_d;
    end
  end
  assign o_valid     = valid_q;
  assign o_sync_data = sync_q;
  assign o_data      = data_q;
  assign o_trans_cnt = trans_q;
endmodule

// File: tb/tb_eth_pcs_rx_gearbox.sv
// tb_eth_pcs_rx_gearbox: bit-queue reference model compared every cycle, plus directed block-level checks
module tb_eth_pcs_rx_gearbox;
  localparam logic [31:0] BASE = 32'h1000_0000;
  typedef struct {logic [1:0] h; logic [31:0] a; logic [31:0] b;} blk_t;
  logic        clk = 0;
  logic        i_reset = 0;
  logic [31:0] i_pma_data = '0;
  logic        i_slip = 0;
  logic        o_valid;
  logic [1:0]  o_sync_data;
  logic [31:0] o_data;
  logic [0:0]  o_trans_cnt;
  int checks = 0, failures = 0;
  bit src[$];
  bit mq[$];
  blk_t ref_q[$];
  bit m_phase = 0, e_valid = 0, e_trans = 0, cmp_en = 0, tracking = 0;
  logic [1:0]  e_sync = '0;
  logic [31:0] e_data = '0;
  int exp_j = 0;
  eth_pcs_rx_gearbox dut (
    .i_clk(clk), .i_reset(i_reset), .i_pma_data(i_pma_data), .i_slip(i_slip),
    .o_valid(o_valid), .o_sync_data(o_sync_data), .o_data(o_data), .o_trans_cnt(o_trans_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference model: the wire is a bit queue; headers take 2 bits, halves take 32
  always @(posedge clk) begin
    if (!i_reset) begin
      mq.delete();
      m_phase = 0; e_valid = 0; e_sync = '0; e_data = '0; e_trans = 0;
    end else begin
      for (int i = 31; i >= 0; i--) mq.push_back(i_pma_data[i]);
      if (i_slip) void'(mq.pop_front());
      if (mq.size() >= (m_phase ? 32 : 34)) begin
        if (!m_phase) for (int i = 0; i < 2; i++) e_sync = {e_sync[0], mq.pop_front()};
        for (int i = 0; i < 32; i++) e_data = {e_data[30:0], mq.pop_front()};
        e_trans = m_phase;
        m_phase = !m_phase;
        e_valid = 1;
      end else e_valid = 0;
    end
  end
  always @(negedge clk) if (cmp_en) begin
    chk("model_valid", o_valid, e_valid);
    chk("model_sync", o_sync_data, e_sync);
    chk("model_data", o_data, e_data);
    chk("model_trans", o_trans_cnt, e_trans);
  end
  task automatic push_blk(input logic [1:0] h, input logic [31:0] a, input logic [31:0] b);
    logic [65:0] v;
    blk_t k;
    v = {h, a, b};
    for (int i = 65; i >= 0; i--) src.push_back(v[i]);
    k.h = h; k.a = a; k.b = b;
    ref_q.push_back(k);
  endtask
  task automatic push_inc(input int n);
    for (int k = 0; k < n; k++) push_blk(k[0] ? 2'b10 : 2'b01, BASE + 32'(k), ~(BASE + 32'(k)));
  endtask
  task automatic observe();
    int found;
    if (!tracking || !o_valid || exp_j >= ref_q.size()) return;
    if (o_trans_cnt == 1'b0) begin
      if (exp_j < 0) begin
        found = -1;
        for (int j = 0; j < ref_q.size() && found < 0; j++)
          if (ref_q[j].h == o_sync_data && ref_q[j].a == o_data) found = j;
        chk("lock_search", found >= 0, 1'b1);
        if (found < 0) begin tracking = 0; return; end
        exp_j = found;
      end
      chk("blk_hdr", o_sync_data, ref_q[exp_j].h);
      chk("blk_w0", o_data, ref_q[exp_j].a);
    end else if (exp_j >= 0) begin
      chk("blk_w1", o_data, ref_q[exp_j].b);
      exp_j++;
    end
  endtask
  task automatic cycle(input bit slip, input bit rst_n = 1);
    logic [31:0] w;
    for (int i = 31; i >= 0; i--) w[i] = src.size() > 0 ? src.pop_front() : 1'b0;
    i_pma_data = w; i_slip = slip; i_reset = rst_n;
    @(posedge clk); #1;
    observe();
  endtask
  task automatic restart();
    tracking = 0;
    src.delete(); ref_q.delete();
    cycle(0, 0); cycle(0, 0);
  endtask
  initial begin
    int idle_n, valid_n, last_idle, n, t;
    @(posedge clk); #1;
    cmp_en = 1;
    // 1: reset state and aligned start
    cycle(0, 0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_sync", o_sync_data, 2'b00);
    chk("rst_trans", o_trans_cnt, 1'b0);
    src.delete(); ref_q.delete();
    push_blk(2'b01, 32'hA5A5_0001, 32'h5A5A_0002);
    push_blk(2'b01, 32'hA5A5_0001, 32'h5A5A_0002);
    cycle(0);
    chk("t1_first_idle", o_valid, 1'b0);
    cycle(0);
    chk("t1_valid0", o_valid, 1'b1);
    chk("t1_sync", o_sync_data, 2'b01);
    chk("t1_w0", o_data, 32'hA5A5_0001);
    chk("t1_trans0", o_trans_cnt, 1'b0);
    cycle(0);
    chk("t1_valid1", o_valid, 1'b1);
    chk("t1_w1", o_data, 32'h5A5A_0002);
    chk("t1_trans1", o_trans_cnt, 1'b1);
    // 2: cadence over 330 words (160 blocks)
    restart();
    push_inc(160);
    tracking = 1; exp_j = 0;
    idle_n = 0; valid_n = 0; last_idle = -1;
    for (int c = 1; c <= 330; c++) begin
      cycle(0);
      if (o_valid) valid_n++;
      else begin
        idle_n++;
        if (last_idle >= 0) chk("t2_idle_spacing", c - last_idle, 33);
        last_idle = c;
      end
    end
    chk("t2_valid_count", valid_n, 320);
    chk("t2_idle_count", idle_n, 10);
    chk("t2_blocks", exp_j, 160);
    // 3: five garbage bits then five separate slips
    restart();
    src.push_back(1); src.push_back(0); src.push_back(1); src.push_back(0); src.push_back(1);
    push_inc(40);
    for (int c = 1; c <= 9; c++) cycle(c[0]);
    tracking = 1; exp_j = -1;
    t = 0;
    while (src.size() > 0 && t < 200) begin cycle(0); t++; end
    repeat (4) cycle(0);
    chk("t3_blocks", exp_j, 40);
    // 4: slip when fill is 2 at phase 0
    restart();
    push_inc(20);
    tracking = 1; exp_j = 0;
    repeat (31) cycle(0);
    chk("t4_pre_valid", o_valid, 1'b1);
    chk("t4_pre_trans", o_trans_cnt, 1'b1);
    tracking = 0;
    cycle(1);
    chk("t4_slip_idle", o_valid, 1'b0);
    cycle(0);
    chk("t4_resume_valid", o_valid, 1'b1);
    chk("t4_resume_trans", o_trans_cnt, 1'b0);
    chk("t4_shift_sync", o_sync_data, 2'b00);
    chk("t4_shift_data", o_data, 32'h2000_001F);
    repeat (6) cycle(0);
    // 5: reset while on the second half
    restart();
    push_inc(10);
    tracking = 1; exp_j = 0;
    t = 0;
    do begin cycle(0); t++; end while (!(o_valid && o_trans_cnt == 1'b1) && t < 10);
    chk("t5_reached_half1", o_trans_cnt, 1'b1);
    cycle(0, 0);
    chk("t5_rst_valid", o_valid, 1'b0);
    chk("t5_rst_sync", o_sync_data, 2'b00);
    chk("t5_rst_data", o_data, 32'h0);
    chk("t5_rst_trans", o_trans_cnt, 1'b0);
    src.delete(); ref_q.delete();
    push_inc(10);
    exp_j = 0;
    cycle(0);
    chk("t5_idle_after_rel", o_valid, 1'b0);
    cycle(0);
    chk("t5_first_valid", o_valid, 1'b1);
    chk("t5_first_sync", o_sync_data, 2'b01);
    chk("t5_first_w0", o_data, BASE);
    repeat (20) cycle(0);
    chk("t5_blocks", exp_j, 10);
    // 6: loopback of random blocks behind a random misalignment
    restart();
    n = $urandom_range(1, 65);
    for (int i = 0; i < n; i++) src.push_back(1'($urandom_range(0, 1)));
    for (int k = 0; k < 1000; k++)
      push_blk($urandom_range(0, 1) ? 2'b01 : 2'b10, $urandom, $urandom);
    for (int c = 1; c < 2*n; c++) cycle(c[0]);
    tracking = 1; exp_j = -1;
    t = 0;
    while (src.size() > 0 && t < 2200) begin cycle(0); t++; end
    repeat (4) cycle(0);
    chk("t6_blocks", exp_j, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
